mandel_pixel_sequencer: RTL and testbench

- Controller in front of the Mandelbrot iteration core (load_Cr / load_Ci / start strobes, byte-wide data bus, 1-bit unbounded flag).
- Accepts one pixel request (Cr, Ci) per valid/ready handshake and shifts both coordinates into the core byte-serially, MSB byte first.
- Steps the core until it reports unbounded or the iteration limit is reached, then returns the iteration count and an escape flag over a valid/ready result channel.
- Sits between the pixel scanner and the core, so the core never needs a host-driven strobe.

---
 rtl/mandel_pixel_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_mandel_pixel_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_pixel_sequencer.sv
// -----------------------------------------------------------------------------
// mandel_pixel_sequencer
//
// Front-end controller for the Mandelbrot iteration core. It accepts one pixel
// request (Cr, Ci, max_iter) per valid/ready handshake. It shifts both
// coordinates into the core byte-serially, MSB byte first, and clears the
// core's Z register. It then steps the core until the core reports unbounded
// or the iteration limit is reached. The iteration count and the escape flag
// are returned on a valid/ready result channel.
//
// Optional feature (compile-time macro MANDEL_SEQ_PERF_EN):
//   adds a saturating 32-bit busy-cycle counter (perf_cycles) with a
//   synchronous clear input (perf_clr). The default build omits both ports.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   max_iter          iteration limit, sampled when a request is accepted
//   req_valid/ready   pixel request handshake; ready only while idle
//   req_cr, req_ci    pixel coordinates, two's complement fixed point
//   res_valid/ready   result handshake
//   res_iter          iterations performed
//   res_escaped       1 = the core reported unbounded
//   core_data         byte to the core (0 when not loading)
//   core_load_cr/ci   coordinate byte strobes
//   core_clear        one-cycle pulse that zeroes the core's Z
//   core_start        one-cycle pulse that performs one iteration
//   core_unbounded    core escape flag, valid STEP_LAT cycles after core_start
//   perf_cycles       (optional) busy-cycle count, saturating
//   perf_clr          (optional) synchronous clear of perf_cycles
// -----------------------------------------------------------------------------
module mandel_pixel_sequencer #(
    parameter int COORD_W  = 16,
    parameter int ITER_W   = 8,
    parameter int STEP_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ITER_W-1:0]   max_iter,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [COORD_W-1:0]  req_cr,
    input  logic [COORD_W-1:0]  req_ci,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ITER_W-1:0]   res_iter,
    output logic                res_escaped,
    output logic [7:0]          core_data,
    output logic                core_load_cr,
    output logic                core_load_ci,
    output logic                core_clear,
    output logic                core_start,
`ifdef MANDEL_SEQ_PERF_EN
    output logic [31:0]         perf_cycles,
    input  logic                perf_clr,
`endif
    input  logic                core_unbounded
);

    localparam int BYTES = COORD_W / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WCW   = (STEP_LAT > 1) ? $clog2(STEP_LAT) : 1;

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [WCW-1:0] LAST_WAIT = WCW'(STEP_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CR,
        LOAD_CI,
        CLEAR,
        STEP,
        WAIT,
        DONE
    } state_t;

    state_t              state;
    logic [COORD_W-1:0]  cr_q;      // shifts left by one byte per cycle
    logic [COORD_W-1:0]  ci_q;
    logic [ITER_W-1:0]   max_q;
    logic [ITER_W-1:0]   iter_cnt;
    logic [BCW-1:0]      byte_cnt;
    logic [WCW-1:0]      wait_cnt;

    // Every output is a register that is updated together with the state.
    // This gives glitch-free strobes to the core. Each strobe is set on
    // entry to its state and cleared on exit, so at most one strobe is ever
    // high.
    // NOTE: sequential state uses non-blocking (<=) assignments only. All
    // registers then read their pre-edge values, regardless of the order in
    // which they are written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cr_q         <= '0;
            ci_q         <= '0;
            max_q        <= '0;
            iter_cnt     <= '0;
            byte_cnt     <= '0;
            wait_cnt     <= '0;
            req_ready    <= 1'b1;
            res_valid    <= 1'b0;
            res_iter     <= '0;
            res_escaped  <= 1'b0;
            core_data    <= '0;
            core_load_cr <= 1'b0;
            core_load_ci <= 1'b0;
            core_clear   <= 1'b0;
            core_start   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        max_q     <= max_iter;
                        iter_cnt  <= '0;
                        byte_cnt  <= '0;
                        req_ready <= 1'b0;
                        if (max_iter == '0) begin
                            // A zero limit produces a result without touching the core.
                            state       <= DONE;
                            res_valid   <= 1'b1;
                            res_iter    <= '0;
                            res_escaped <= 1'b0;
                        end else begin
                            state        <= LOAD_CR;
                            core_load_cr <= 1'b1;
                            core_data    <= req_cr[COORD_W-1 -: 8];
                            cr_q         <= req_cr << 8;
                            ci_q         <= req_ci;
                        end
                    end
                end

                LOAD_CR: begin
                    if (byte_cnt == LAST_BYTE) begin
                        state        <= LOAD_CI;
                        byte_cnt     <= '0;
                        core_load_cr <= 1'b0;
                        core_load_ci <= 1'b1;
                        core_data    <= ci_q[COORD_W-1 -: 8];
                        ci_q         <= ci_q << 8;
                    end else begin
                        byte_cnt  <= byte_cnt + 1'b1;
                        core_data <= cr_q[COORD_W-1 -: 8];
                        cr_q      <= cr_q << 8;
                    end
                end

                LOAD_CI: begin
                    if (byte_cnt == LAST_BYTE) begin
                        state        <= CLEAR;
                        byte_cnt     <= '0;
                        core_load_ci <= 1'b0;
                        core_data    <= '0;
                        core_clear   <= 1'b1;
                    end else begin
                        byte_cnt  <= byte_cnt + 1'b1;
                        core_data <= ci_q[COORD_W-1 -: 8];
                        ci_q      <= ci_q << 8;
                    end
                end

                CLEAR: begin
                    state      <= STEP;
                    core_clear <= 1'b0;
                    core_start <= 1'b1;
                    iter_cnt   <= iter_cnt + 1'b1;
                end

                STEP: begin
                    state      <= WAIT;
                    core_start <= 1'b0;
                    wait_cnt   <= '0;
                end

                WAIT: begin
                    // core_unbounded is meaningful only in the last WAIT cycle.
                    if (wait_cnt == LAST_WAIT) begin
                        if (core_unbounded) begin
                            state       <= DONE;
                            res_valid   <= 1'b1;
                            res_iter    <= iter_cnt;
                            res_escaped <= 1'b1;
                        end else if (iter_cnt == max_q) begin
                            state       <= DONE;
                            res_valid   <= 1'b1;
                            res_iter    <= iter_cnt;
                            res_escaped <= 1'b0;
                        end else begin
                            state      <= STEP;
                            core_start <= 1'b1;
                            iter_cnt   <= iter_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        res_valid   <= 1'b0;
                        res_iter    <= '0;
                        res_escaped <= 1'b0;
                        req_ready   <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef MANDEL_SEQ_PERF_EN
    // Counts every cycle spent working on a pixel. It saturates instead of
    // wrapping. A clear takes priority over an increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (perf_clr) begin
            perf_cycles <= '0;
        end else if (state != IDLE && state != DONE && perf_cycles != '1) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mandel_pixel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mandel_pixel_sequencer
//
// Directed and randomized pixels are driven through the sequencer against a
// behavioural core. The core answers core_unbounded exactly STEP_LAT cycles
// after each core_start and drives random values at all other times. Each
// expected result is computed from the pixel's escape step and its limit:
// the count, the escape flag, the latency, and the full strobe/byte
// sequence seen by the core.
// -----------------------------------------------------------------------------
module tb_mandel_pixel_sequencer;

    localparam int COORD_W  = 16;
    localparam int ITER_W   = 8;
    localparam int STEP_LAT = 2;
    localparam int BYTES    = COORD_W / 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [ITER_W-1:0]  max_iter = '0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [COORD_W-1:0] req_cr = '0;
    logic [COORD_W-1:0] req_ci = '0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [ITER_W-1:0]  res_iter;
    logic               res_escaped;
    logic [7:0]         core_data;
    logic               core_load_cr;
    logic               core_load_ci;
    logic               core_clear;
    logic               core_start;
    logic               core_unbounded = 1'b0;
`ifdef MANDEL_SEQ_PERF_EN
    logic [31:0]        perf_cycles;
    logic               perf_clr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Core model and strobe monitor state
    int          esc_k = 0;      // step at which the core escapes (0 = never)
    int          starts = 0;     // core_start pulses in the current pixel
    int          since = 99;     // cycles since the last core_start
    int          bad_strobes = 0;
    logic [10:0] log_q[$];       // {kind[2:0], byte}: 1=cr 2=ci 3=clear 4=start

    mandel_pixel_sequencer #(
        .COORD_W (COORD_W),
        .ITER_W  (ITER_W),
        .STEP_LAT(STEP_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .max_iter      (max_iter),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cr        (req_cr),
        .req_ci        (req_ci),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_iter      (res_iter),
        .res_escaped   (res_escaped),
        .core_data     (core_data),
        .core_load_cr  (core_load_cr),
        .core_load_ci  (core_load_ci),
        .core_clear    (core_clear),
        .core_start    (core_start),
`ifdef MANDEL_SEQ_PERF_EN
        .perf_cycles   (perf_cycles),
        .perf_clr      (perf_clr),
`endif
        .core_unbounded(core_unbounded)
    );

    always #5 clk = ~clk;

    // Observe the core interface mid-cycle and play the core's part.
    always @(negedge clk) begin
        if (!rst_n) begin
            since = 99;
        end else begin
            if (req_ready) begin
                log_q.delete();
                starts = 0;
            end
            if ($countones({core_load_cr, core_load_ci, core_clear, core_start}) > 1)
                bad_strobes++;
            if (!core_load_cr && !core_load_ci && core_data != 8'h00)
                bad_strobes++;
            if (core_load_cr) log_q.push_back({3'd1, core_data});
            if (core_load_ci) log_q.push_back({3'd2, core_data});
            if (core_clear)   log_q.push_back({3'd3, 8'h00});
            if (core_start) begin
                log_q.push_back({3'd4, 8'h00});
                starts++;
                since = 0;
            end else if (since < 99) begin
                since++;
            end
            if (since == STEP_LAT)
                core_unbounded = (esc_k != 0) && (starts >= esc_k);
            else
                core_unbounded = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One complete pixel: request, result check, optional back-pressure, handshake.
    task automatic run_pixel(input logic [15:0] cr, input logic [15:0] ci,
                             input logic [7:0] mi, input int esc, input int hold);
        int          n;
        logic        escd;
        int          exp_lat;
        int          lat;
        bit          seen;
        bit          stable;
        logic [10:0] exp_q[$];

        if (esc != 0 && esc <= int'(mi)) begin
            n = esc;
            escd = 1'b1;
        end else begin
            n = int'(mi);
            escd = 1'b0;
        end
        exp_lat = (mi == 0) ? 1 : 2 * BYTES + 1 + n * (1 + STEP_LAT) + 1;
        if (mi != 0) begin
            for (int b = 0; b < BYTES; b++) exp_q.push_back({3'd1, cr[COORD_W-1-8*b -: 8]});
            for (int b = 0; b < BYTES; b++) exp_q.push_back({3'd2, ci[COORD_W-1-8*b -: 8]});
            exp_q.push_back({3'd3, 8'h00});
            for (int s = 0; s < n; s++) exp_q.push_back({3'd4, 8'h00});
        end

        esc_k = esc;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_cr = cr;
        req_ci = ci;
        max_iter = mi;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the request inputs so that any unlatched use shows up.
        req_valid = 1'b0;
        req_cr = 16'($urandom);
        req_ci = 16'($urandom);
        max_iter = 8'($urandom);

        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("req_ready_busy", 32'(req_ready), 32'd0);
            if (res_valid) seen = 1'b1;
        end
        check("res_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("res_iter", 32'(res_iter), 32'(n));
        check("res_escaped", 32'(res_escaped), 32'(escd));
        check("core_seq_len", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("core_seq[%0d]", i), 32'(log_q[i]), 32'(exp_q[i]));

        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!(res_valid === 1'b1 && res_iter === 8'(n) &&
                  res_escaped === escd && req_ready === 1'b0))
                stable = 1'b0;
        end
        if (hold > 0) check("backpressure_stable", 32'(stable), 32'd1);

        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("req_ready_after_hs", 32'(req_ready), 32'd1);
        check("res_valid_after_hs", 32'(res_valid), 32'd0);
        check("strobe_rules", 32'(bad_strobes), 32'd0);
    endtask

    initial begin
        int quiet;

        // Reset state
        #12;
        check("reset_outputs",
              32'({res_valid, res_iter, res_escaped, core_data,
                   core_load_cr, core_load_ci, core_clear, core_start}), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Never escapes: the full limit is used.
        run_pixel(16'h0000, 16'h0000, 8'd16, 0, 0);
        // Escapes on the first step: shortest core path.
        run_pixel(16'h2000, 16'h0000, 8'd16, 1, 0);
        // Byte ordering of both coordinates.
        run_pixel(16'h1234, 16'hABCD, 8'd3, 0, 0);
        // Zero limit: the core is untouched.
        run_pixel(16'h5A5A, 16'hA5A5, 8'd0, 3, 0);
        // Escape on the final permitted step: escape wins.
        run_pixel(16'h0F0F, 16'hF0F0, 8'd5, 5, 0);
        // Escape one step past the limit: not seen.
        run_pixel(16'h7777, 16'h8888, 8'd5, 6, 0);
        // Result back-pressure.
        run_pixel(16'hC001, 16'h0C0C, 8'd7, 4, 20);
        // Largest limit, no wrap of the counter.
        run_pixel(16'hFFFF, 16'h8000, 8'd255, 0, 0);

        // Randomized pixels
        for (int p = 0; p < 10; p++)
            run_pixel(16'($urandom), 16'($urandom), 8'($urandom_range(0, 12)),
                      int'($urandom_range(0, 14)), int'($urandom_range(0, 3)));

        // Reset in the middle of WAIT aborts the pixel.
        esc_k = 0;
        @(negedge clk);
        req_cr = 16'h4321;
        req_ci = 16'h8765;
        max_iter = 8'd16;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs",
              32'({res_valid, res_iter, res_escaped, core_data,
                   core_load_cr, core_load_ci, core_clear, core_start}), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || req_ready !== 1'b1) quiet++;
        end
        check("midrst_no_result", 32'(quiet), 32'd0);
        run_pixel(16'h0100, 16'hFF00, 8'd9, 2, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
